// File: rtl/cfpga_reg_master_if.sv
// Command/response handshake and channel register-link signals of the channel-FPGA
// register initiator.
interface cfpga_reg_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_reg;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] cf_data;
    logic        cf_reg_num_le;
    logic        cf_wr_en;
    logic        cf_rd_en;
    logic [31:0] cf_rdata;
    logic        cf_illegal;

    logic        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_reg, cmd_wdata, rsp_ready, cf_rdata, cf_illegal,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, cf_data, cf_reg_num_le, cf_wr_en,
               cf_rd_en, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_reg, cmd_wdata, rsp_ready, cf_rdata, cf_illegal,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, cf_data, cf_reg_num_le, cf_wr_en,
               cf_rd_en, busy
    );
endinterface

// File: rtl/cfpga_reg_master.sv
// Master-side initiator for the channel-FPGA register link: turns one command into the
// select / write / read strobe sequence and returns a single response.
module cfpga_reg_master #(
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          CACHE_SEL  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    cfpga_reg_master_if.master bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StChk,
        StWr,
        StRd,
        StRwait,
        StResp
    } state_e;

    localparam logic [3:0] RdLat = 4'(RD_LATENCY);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] reg_q, reg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] sel_reg_q, sel_reg_d;
    logic        sel_valid_q, sel_valid_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] cf_data_q, cf_data_d;
    logic        le_q, le_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        cache_hit;
    logic [31:0] eff_reg;
    logic [31:0] eff_wdata;

    always_comb begin
        accept    = bus_io.cmd_valid && cmd_ready_q;
        cache_hit = CACHE_SEL && sel_valid_q && (bus_io.cmd_reg == sel_reg_q);

        state_d     = state_q;
        write_d     = write_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        sel_reg_d   = sel_reg_q;
        sel_valid_d = sel_valid_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = bus_io.cmd_write;
                    reg_d   = bus_io.cmd_reg;
                    wdata_d = bus_io.cmd_wdata;
                    if (cache_hit) begin
                        state_d = bus_io.cmd_write ? StWr : StRd;
                    end else begin
                        state_d = StSel;
                    end
                end
            end
            StSel: begin
                sel_reg_d = reg_q;
                state_d   = StChk;
            end
            StChk: begin
                // cf_illegal now reflects the number latched by the SEL strobe
                if (bus_io.cf_illegal) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    sel_valid_d = 1'b0;
                    state_d     = StResp;
                end else begin
                    sel_valid_d = 1'b1;
                    state_d     = write_q ? StWr : StRd;
                end
            end
            StWr: begin
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
                state_d     = StResp;
            end
            StRd: begin
                cnt_d   = RdLat;
                state_d = StRwait;
            end
            StRwait: begin
                if (cnt_q <= 4'd1) begin
                    rsp_rdata_d = bus_io.cf_rdata;
                    rsp_err_d   = 1'b0;
                    cnt_d       = '0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus_io.rsp_ready) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so each strobe is high exactly in its state.
    always_comb begin
        eff_reg   = (state_q == StIdle) ? bus_io.cmd_reg : reg_q;
        eff_wdata = (state_q == StIdle) ? bus_io.cmd_wdata : wdata_q;

        le_d        = (state_d == StSel);
        wr_d        = (state_d == StWr);
        rd_d        = (state_d == StRd);
        rsp_valid_d = (state_d == StResp);
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);

        case (state_d)
            StSel:   cf_data_d = eff_reg;
            StWr:    cf_data_d = eff_wdata;
            default: cf_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            reg_q       <= '0;
            wdata_q     <= '0;
            sel_reg_q   <= '0;
            sel_valid_q <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cf_data_q   <= '0;
            le_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            sel_reg_q   <= sel_reg_d;
            sel_valid_q <= sel_valid_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cf_data_q   <= cf_data_d;
            le_q        <= le_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus_io.cmd_ready     = cmd_ready_q;
    assign bus_io.rsp_valid     = rsp_valid_q;
    assign bus_io.rsp_rdata     = rsp_rdata_q;
    assign bus_io.rsp_err       = rsp_err_q;
    assign bus_io.cf_data       = cf_data_q;
    assign bus_io.cf_reg_num_le = le_q;
    assign bus_io.cf_wr_en      = wr_q;
    assign bus_io.cf_rd_en      = rd_q;
    assign bus_io.busy          = busy_q;

endmodule
